fwd_hazard_unit: RTL



---
 rtl/fwd_hazard_if.sv | 39 +++
 rtl/fwd_hazard_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_if.sv
// Decode <-> forwarding/hazard unit bundle.
// master = decode side (drives issue/operand info), slave = the unit.
interface fwd_hazard_if #(
    parameter int RA_W  = 5,
    parameter int SW    = 1,
    parameter int CNT_W = 32
);
    logic             issue_valid;
    logic [RA_W-1:0]  issue_rd;
    logic             issue_wb_en;
    logic [1:0]       issue_kind;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic             rs1_used;
    logic             rs2_used;
    logic             flush;
    logic             fwd_hit_1;
    logic             fwd_hit_2;
    logic [SW-1:0]    fwd_stage_1;
    logic [SW-1:0]    fwd_stage_2;
    logic [1:0]       fwd_kind_1;
    logic [1:0]       fwd_kind_2;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output issue_valid, issue_rd, issue_wb_en, issue_kind,
        output rs1, rs2, rs1_used, rs2_used, flush,
        input  fwd_hit_1, fwd_hit_2, fwd_stage_1, fwd_stage_2,
        input  fwd_kind_1, fwd_kind_2, stall, stall_count
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wb_en, issue_kind,
        input  rs1, rs2, rs1_used, rs2_used, flush,
        output fwd_hit_1, fwd_hit_2, fwd_stage_1, fwd_stage_2,
        output fwd_kind_1, fwd_kind_2, stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Keeps a DEPTH-entry shift register of in-flight register writers
// (entry 0 = execute, DEPTH-1 = writeback) and, for each decode operand,
// reports the youngest matching producer and whether its data is ready.

// Per-operand producer lookup against the tracker.
module fwd_lookup #(
    parameter int DEPTH    = 2,
    parameter int RA_W     = 5,
    parameter int SW       = 1,
    parameter int LOAD_LAT = 0
) (
    input  logic [DEPTH-1:0]           ent_vld,
    input  logic [DEPTH-1:0][RA_W-1:0] ent_rd,
    input  logic [DEPTH-1:0][1:0]      ent_kind,
    input  logic [RA_W-1:0]            rs,
    input  logic                       used,
    output logic                       hit,
    output logic [SW-1:0]              stage,
    output logic [1:0]                 kind,
    output logic                       load_haz
);
    // Scan oldest to youngest so the lowest matching index overwrites last.
    always_comb begin
        hit      = 1'b0;
        stage    = '0;
        kind     = 2'd0;
        load_haz = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (used && (rs != '0) && ent_vld[i] && (ent_rd[i] == rs)) begin
                hit      = 1'b1;
                stage    = SW'(i);
                kind     = ent_kind[i];
                // Load data only exists from entry LOAD_LAT onward.
                load_haz = (ent_kind[i] == 2'd1) && (i < LOAD_LAT);
            end
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 0,
    parameter int RA_W     = 5,
    parameter int CNT_W    = 32,
    localparam int SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input logic         clk,
    input logic         rst,
    fwd_hazard_if.slave bus
);
    typedef struct packed {
        logic            vld;
        logic [RA_W-1:0] rd;
        logic [1:0]      kind;
    } ent_t;

    // Tracker state, one bit/field per post-issue stage.
    logic [DEPTH-1:0]           vld_pipe;
    logic [DEPTH-1:0][RA_W-1:0] ent_rd;
    logic [DEPTH-1:0][1:0]      ent_kind;

    logic [1:0][RA_W-1:0] rs_a;
    logic [1:0]           used_a;
    logic [1:0]           hit_a;
    logic [1:0][SW-1:0]   stage_a;
    logic [1:0][1:0]      kind_a;
    logic [1:0]           haz_a;

    logic             stall;
    logic [CNT_W-1:0] cnt;
    ent_t             ent_new;

    assign rs_a   = {bus.rs2, bus.rs1};
    assign used_a = {bus.rs2_used, bus.rs1_used};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lkp
            fwd_lookup #(
                .DEPTH    (DEPTH),
                .RA_W     (RA_W),
                .SW       (SW),
                .LOAD_LAT (LOAD_LAT)
            ) u_lkp (
                .ent_vld  (vld_pipe),
                .ent_rd   (ent_rd),
                .ent_kind (ent_kind),
                .rs       (rs_a[g]),
                .used     (used_a[g]),
                .hit      (hit_a[g]),
                .stage    (stage_a[g]),
                .kind     (kind_a[g]),
                .load_haz (haz_a[g])
            );
        end
    endgenerate

    assign stall = |haz_a;

    // Candidate for entry 0: bubble on stall or flush, and rd=x0 never tracked.
    always_comb begin
        ent_new      = '0;
        ent_new.vld  = bus.issue_valid && bus.issue_wb_en && (bus.issue_rd != '0)
                       && !stall && !bus.flush;
        ent_new.rd   = bus.issue_rd;
        ent_new.kind = bus.issue_kind;
    end

    // Shift the tracker; flush drops the current entry 0 instead of advancing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            ent_rd   <= '0;
            ent_kind <= '0;
        end else begin
            vld_pipe[0] <= ent_new.vld;
            ent_rd[0]   <= ent_new.rd;
            ent_kind[0] <= ent_new.kind;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= (i == 1 && bus.flush) ? 1'b0 : vld_pipe[i-1];
                ent_rd[i]   <= ent_rd[i-1];
                ent_kind[i] <= ent_kind[i-1];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (stall && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign bus.fwd_hit_1   = hit_a[0];
    assign bus.fwd_hit_2   = hit_a[1];
    assign bus.fwd_stage_1 = stage_a[0];
    assign bus.fwd_stage_2 = stage_a[1];
    assign bus.fwd_kind_1  = kind_a[0];
    assign bus.fwd_kind_2  = kind_a[1];
    assign bus.stall       = stall;
    assign bus.stall_count = cnt;
endmodule
